shift_unit_n: RTL and testbench
===============================

Name: shift_unit_n

Overview:
- Parametrised, multi-cycle shift/rotate unit for the multicycle datapath.
- Resolves the shift amount from one of four sources:
  - a constant,
  - the instruction shamt field,
  - the low bits of register B,
  - register B saturated to the data width.
- Shifts the latched operand by STEP bits per cycle under a start/busy/done handshake, so the control FSM can stall on it.
- Sits between the register file/ALU operand path and the result write-back mux.

Parameters:
- DATA_W, 32, operand/result width; power of two, at least 8.
- AMT_W, $clog2(DATA_W), width of the shamt field and of the non-saturated amount.
- CONST_AMT, 16, amount used when amt_sel=00; must be at most DATA_W.
- STEP, 1, bits shifted per cycle; power of two, 1 to DATA_W/2.

Ports:
- clk, input, 1, system clock; rising edge.
- reset, input, 1, asynchronous active-low reset.
- start, input, 1, request pulse; sampled only in IDLE or DONE.
- op, input, 3, 000 NOP, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR; 110/111 behave as NOP.
- amt_sel, input, 2, amount source: 00 CONST_AMT, 01 shamt, 10 b_amt[AMT_W-1:0], 11 b_amt saturated.
- shamt, input, AMT_W, instruction shift-amount field.
- b_amt, input, DATA_W, register B value.
- data_in, input, DATA_W, operand to shift.
- data_out, output, DATA_W, result; held until the next accepted start.
- busy, output, 1, high while in SHIFT.
- done, output, 1, one-cycle pulse when the result is valid.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, data_out=0, busy=0, done=0, remaining=0.
  - Reset mid-SHIFT aborts the operation; the partial result is discarded.
- Amount resolution is combinational and yields an (AMT_W+1)-bit amount `amt`:
  - sel 00 → CONST_AMT.
  - sel 01 → shamt.
  - sel 10 → b_amt[AMT_W-1:0].
  - sel 11 → DATA_W if b_amt ≥ DATA_W (any upper bit set), else b_amt.
- Amount adjustment for op:
  - NOP: amt forced to 0.
  - ROL/ROR: amt reduced mod DATA_W, so a saturated amount rotates by 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, start=1: latch data_in into the work register; latch op and adjusted amt into remaining. Go to SHIFT if amt≠0, else DONE.
  - SHIFT, each cycle:
    - k = min(STEP, remaining).
    - Shift the work register by k: SLL zero-fill; SRL zero-fill; SRA sign-fill from the current MSB; ROL/ROR circular.
    - remaining -= k.
    - If the new remaining is 0, go to DONE.
    - start is ignored.
  - DONE: done=1; data_out = work register (registered on entry to DONE).
    - start=1 here is accepted exactly as in IDLE (back-to-back operation).
    - Otherwise go to IDLE.
- Latency, with the accepting edge as edge 0: done is high during cycle ceil(amt/STEP)+1.
  - amt=0 gives done in cycle 1.
- busy=1 exactly in SHIFT; busy and done are never high together.
- A full shift (amt=DATA_W): SLL/SRL yield 0; SRA yields all copies of the sign bit.
- Inputs other than start are don't-care after acceptance; only latched values are used.

Decomposition:
- Package shift_pkg holds:
  - op codes (OP_NOP, OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR);
  - amt_sel codes (AMT_CONST, AMT_SHAMT, AMT_B, AMT_B_SAT);
  - the state enum (S_IDLE, S_SHIFT, S_DONE).
- One combinational sub-module, shift_amt_sel, performs source selection, saturation and op-dependent adjustment.
- The top level holds the FSM, the work register and the per-step shifter.

Test Plan:
- Defaults, op=SLL, amt_sel=01, shamt=3, data_in=0x0000_0001, start in cycle 0 → busy in cycles 1–3, done in cycle 4, data_out=0x0000_0008.
- op=SRA, amt_sel=10, b_amt=0x0000_0025 (low 5 bits = 5), data_in=0x8000_0000 → data_out=0xFC00_0000, done in cycle 6.
- amt_sel=11, b_amt=40, data_in=0xFFFF_FFFF:
  - SRL → 0x0000_0000, done in cycle 33;
  - SRA → 0xFFFF_FFFF, done in cycle 33;
  - ROR → 0xFFFF_FFFF, done in cycle 1, busy never asserted.
- STEP=4, op=ROL, amt_sel=00 (CONST_AMT=16), data_in=0x1234_5678 → data_out=0x5678_1234, done in cycle 5.
- Back-to-back and busy-protect:
  - start pulses during SHIFT are ignored (data_out and timing unchanged).
  - A start held high in the DONE cycle with op=NOP launches a second operation; done is high again one cycle later and data_out=new data_in.
- Reset mid-operation: reset=0 in cycle 2 of a 10-bit SLL → busy=0, done=0, data_out=0 immediately, state IDLE. After release, a fresh start completes normally with the correct result.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared op, amount-source and state encodings for the multicycle shift unit.
// Imported by the amount selector and the shift FSM.
package shift_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  localparam logic [1:0] AMT_CONST = 2'b00;
  localparam logic [1:0] AMT_SHAMT = 2'b01;
  localparam logic [1:0] AMT_B     = 2'b10;
  localparam logic [1:0] AMT_B_SAT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

endpackage

// File: rtl/shift_amt_sel.sv
// Shift amount resolution: source select, saturation and op adjustment.
// Purely combinational; the result is AMT_W+1 bits so DATA_W fits.
module shift_amt_sel
  import shift_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int AMT_W     = $clog2(DATA_W),
  parameter int CONST_AMT = 16
) (
  input  logic [2:0]        op,
  input  logic [1:0]        amt_sel,
  input  logic [AMT_W-1:0]  shamt,
  input  logic [DATA_W-1:0] b_amt,
  output logic [AMT_W:0]    amt
);

  logic [AMT_W:0] raw;
  logic           big;

  assign big = |b_amt[DATA_W-1:AMT_W];

  always_comb begin
    raw = '0;
    unique case (1'b1)
      (amt_sel == AMT_CONST): raw = (AMT_W+1)'(CONST_AMT);
      (amt_sel == AMT_SHAMT): raw = {1'b0, shamt};
      (amt_sel == AMT_B):     raw = {1'b0, b_amt[AMT_W-1:0]};
      default: begin
        raw = big ? (AMT_W+1)'(DATA_W) : {1'b0, b_amt[AMT_W-1:0]};
      end
    endcase
  end

  // Rotates wrap modulo DATA_W, so a saturated amount rotates by zero.
  always_comb begin
    amt = '0;
    unique case (1'b1)
      (op == OP_ROL), (op == OP_ROR): amt = {1'b0, raw[AMT_W-1:0]};
      (op == OP_SLL), (op == OP_SRL), (op == OP_SRA): amt = raw;
      default: amt = '0;
    endcase
  end

endmodule

// File: rtl/shift_unit_n.sv
// Multicycle shift/rotate unit: STEP bits per cycle under start/busy/done.
// The work register holds the operand; data_out updates on entry to DONE.
module shift_unit_n
  import shift_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int AMT_W     = $clog2(DATA_W),
  parameter int CONST_AMT = 16,
  parameter int STEP      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [1:0]        amt_sel,
  input  logic [AMT_W-1:0]  shamt,
  input  logic [DATA_W-1:0] b_amt,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam logic [AMT_W:0] STEP_A = (AMT_W+1)'(STEP);
  localparam logic [AMT_W:0] FULL   = (AMT_W+1)'(DATA_W);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] work;
  logic [DATA_W-1:0] shifted;
  logic [AMT_W:0]    amt;
  logic [AMT_W:0]    remaining;
  logic [AMT_W:0]    rem_nxt;
  logic [AMT_W:0]    k;
  logic [AMT_W:0]    kc;
  logic [2:0]        op_q;
  logic              accept;

  shift_amt_sel #(
    .DATA_W    (DATA_W),
    .AMT_W     (AMT_W),
    .CONST_AMT (CONST_AMT)
  ) u_amt (
    .op      (op),
    .amt_sel (amt_sel),
    .shamt   (shamt),
    .b_amt   (b_amt),
    .amt     (amt)
  );

  assign accept  = start && (state == S_IDLE || state == S_DONE);
  assign k       = (remaining > STEP_A) ? STEP_A : remaining;
  assign kc      = FULL - k;
  assign rem_nxt = remaining - k;
  assign busy    = (state == S_SHIFT);
  assign done    = (state == S_DONE);

  always_comb begin
    shifted = work;
    unique case (1'b1)
      (op_q == OP_SLL): shifted = work << k;
      (op_q == OP_SRL): shifted = work >> k;
      (op_q == OP_SRA): shifted = $signed(work) >>> k;
      (op_q == OP_ROL): shifted = (work << k) | (work >> kc);
      (op_q == OP_ROR): shifted = (work >> k) | (work << kc);
      default:          shifted = work;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = (amt != '0) ? S_SHIFT : S_DONE;
        else        state_nxt = S_IDLE;
      end
      S_SHIFT: begin
        if (rem_nxt == '0) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work      <= '0;
      op_q      <= OP_NOP;
      remaining <= '0;
      data_out  <= '0;
    end else begin
      if (accept) begin
        work      <= data_in;
        op_q      <= op;
        remaining <= amt;
      end else if (state == S_SHIFT) begin
        work      <= shifted;
        remaining <= rem_nxt;
      end
      // Zero-amount ops bypass SHIFT and publish the operand directly.
      if (accept && amt == '0) begin
        data_out <= data_in;
      end else if (state == S_SHIFT && rem_nxt == '0) begin
        data_out <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_n.sv
// Scoreboard bench for shift_unit_n with STEP=4 against a reference model.
// A driver queues expected results; a negedge monitor pops and compares.
module tb_shift_unit_n;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int CA = 16;
  localparam int ST = 4;

  typedef struct {
    logic [W-1:0] res;
    int           dc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [1:0]    amt_sel = '0;
  logic [AW-1:0] shamt = '0;
  logic [W-1:0]  b_amt = '0;
  logic [W-1:0]  data_in = '0;
  logic [W-1:0]  data_out;
  logic          busy;
  logic          done;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   next_free = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  exp_t e;

  shift_unit_n #(
    .DATA_W    (W),
    .AMT_W     (AW),
    .CONST_AMT (CA),
    .STEP      (ST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .amt_sel  (amt_sel),
    .shamt    (shamt),
    .b_amt    (b_amt),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int model_amt(logic [2:0] o, logic [1:0] s,
                                   logic [AW-1:0] sh, logic [W-1:0] b);
    longint unsigned bv;
    int a;
    bv = b;
    case (s)
      2'd0:    a = CA;
      2'd1:    a = int'(sh);
      2'd2:    a = int'(bv % W);
      default: a = (bv >= W) ? W : int'(bv);
    endcase
    if (o == 3'd4 || o == 3'd5) a = a % W;
    else if (o == 3'd0 || o > 3'd5) a = 0;
    return a;
  endfunction

  function automatic logic [W-1:0] model_res(logic [2:0] o, int a,
                                             logic [W-1:0] d);
    logic [W-1:0] r;
    case (o)
      3'd1: r = (a >= W) ? '0 : d << a;
      3'd2: r = (a >= W) ? '0 : d >> a;
      3'd3: r = (a >= W) ? {W{d[W-1]}} : W'($signed(d) >>> a);
      3'd4: r = (a == 0) ? d : (d << a) | (d >> (W - a));
      3'd5: r = (a == 0) ? d : (d >> a) | (d << (W - a));
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  task automatic scramble();
    op      = 3'($urandom);
    amt_sel = 2'($urandom);
    shamt   = AW'($urandom);
    b_amt   = $urandom;
    data_in = $urandom;
  endtask

  always @(negedge clk) begin
    if (mon_en && reset) begin
      check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check("data_out", 64'(data_out), 64'(e.res));
          check("done_cycle", 64'(cyc), 64'(e.dc));
        end
      end else if (q.size() != 0 && cyc >= q[0].dc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL done_missing: got 0 expected 1 (cycle %0d)", cyc);
      end
    end
  end

  task automatic issue(logic [2:0] o, logic [1:0] s, logic [AW-1:0] sh,
                       logic [W-1:0] b, logic [W-1:0] d,
                       int gap, bit noise);
    int a;
    int n;
    while (cyc < next_free) begin
      scramble();
      start = noise && ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (gap) @(negedge clk);
    op      = o;
    amt_sel = s;
    shamt   = sh;
    b_amt   = b;
    data_in = d;
    start   = 1'b1;
    a = model_amt(o, s, sh, b);
    n = (a + ST - 1) / ST;
    q.push_back('{model_res(o, a, d), cyc + 1 + n});
    busy_lo   = cyc + 1;
    busy_hi   = cyc + n;
    next_free = cyc + 1 + n;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    repeat (2) @(negedge clk);
    #2;
    reset  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    issue(3'd1, 2'd1, 5'd3, 32'h0, 32'h0000_0001, 1, 1'b0);
    issue(3'd3, 2'd2, 5'd0, 32'h0000_0025, 32'h8000_0000, 1, 1'b0);
    issue(3'd2, 2'd3, 5'd0, 32'd40, 32'hFFFF_FFFF, 0, 1'b0);
    issue(3'd3, 2'd3, 5'd0, 32'd40, 32'hFFFF_FFFF, 1, 1'b1);
    issue(3'd5, 2'd3, 5'd0, 32'd40, 32'hFFFF_FFFF, 2, 1'b0);
    issue(3'd4, 2'd0, 5'd0, 32'h0, 32'h1234_5678, 1, 1'b1);
    issue(3'd0, 2'd1, 5'd9, 32'h0, 32'hCAFE_F00D, 0, 1'b1);
    issue(3'd7, 2'd3, 5'd7, 32'd5, 32'h0BAD_BEEF, 0, 1'b0);
    issue(3'd2, 2'd0, 5'd0, 32'h0, 32'hA5A5_0000, 0, 1'b1);

    issue(3'd1, 2'd1, 5'd10, 32'h0, 32'h0000_0003, 1, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_data_out", 64'(data_out), 64'd0);
    q.delete();
    busy_lo   = 1;
    busy_hi   = 0;
    next_free = 0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    issue(3'd1, 2'd1, 5'd10, 32'h0, 32'h0000_0003, 1, 1'b0);

    for (int i = 0; i < 250; i++) begin
      logic [W-1:0] b;
      b = ($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(0, 40));
      issue(3'($urandom), 2'($urandom), AW'($urandom), b, $urandom,
            $urandom_range(0, 2), 1'b1);
    end

    while (cyc <= next_free + 1) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
